vpe_relu_ctrl: RTL

//  Sequencer for the VPE ReLU stage. Accepts one vector command at a time.

---
 rtl/vpe_relu_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/vpe_relu_ctrl.sv
// vpe_relu_ctrl: sequencer that streams one vector command from the register file
// through the ReLU stage. It issues grant-gated RF reads, delays each accepted
// read by the RF latency to present a ReLU beat, and counts write-backs for completion.
module vpe_relu_ctrl #(
   parameter int RF_DEPTH = 32,
   parameter int IDX_W    = 5,
   parameter int LEN_W    = 6,
   parameter int RD_LAT   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [IDX_W-1:0] cmd_src_base,
   input  logic [IDX_W-1:0] cmd_dst_base,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             cmd_relu,
   input  logic [1:0]       cmd_mux,
   output logic             rf_rd_req,
   output logic [IDX_W-1:0] rf_rd_idx,
   input  logic             rf_rd_gnt,
   output logic             relu_data_v,
   output logic             relu_en,
   output logic [IDX_W-1:0] relu_rf_idx,
   output logic [1:0]       relu_rf_mux,
   input  logic             wb_v,
   output logic             busy,
   output logic             done,
   output logic             err_len
);

   // One extra bit so a full-depth command length is representable in the counters.
   localparam int CNT_W = LEN_W + 1;
   // RF_DEPTH is a power of two, so modulo reduces to a mask on the index sum.
   localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(RF_DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] src_q, src_d;
   logic [IDX_W-1:0] dst_q, dst_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             relu_q, relu_d;
   logic [1:0]       mux_q, mux_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] issued_q, issued_d;
   logic [CNT_W-1:0] ret_q, ret_d;

   // Delay line: one slot per cycle of RF read latency, carrying beat valid and destination.
   logic [RD_LAT-1:0] dl_v_q, dl_v_d;
   logic [IDX_W-1:0]  dl_idx_q [RD_LAT];
   logic [IDX_W-1:0]  dl_idx_d [RD_LAT];

   logic             rd_fire;
   logic [CNT_W-1:0] len_ext;
   logic [CNT_W-1:0] ret_inc;
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] wr_idx;

   assign len_ext = {1'b0, len_q};
   assign ret_inc = ret_q + CNT_W'(wb_v);
   assign rd_idx  = (src_q + issued_q[IDX_W-1:0]) & IDX_MASK;
   assign wr_idx  = (dst_q + issued_q[IDX_W-1:0]) & IDX_MASK;
   assign rd_fire = (state_q == S_ISSUE) && rf_rd_gnt;

   // Delay-line shift: stage 0 takes the read accepted this cycle, later stages follow.
   assign dl_v_d[0]   = rd_fire;
   assign dl_idx_d[0] = wr_idx;
   for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_dly
      assign dl_v_d[gi]   = dl_v_q[gi-1];
      assign dl_idx_d[gi] = dl_idx_q[gi-1];
   end

   // Next-state and command/counter bookkeeping.
   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      len_d    = len_q;
      relu_d   = relu_q;
      mux_d    = mux_q;
      err_d    = err_q;
      issued_d = issued_q;
      ret_d    = ret_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               src_d    = cmd_src_base;
               dst_d    = cmd_dst_base;
               len_d    = cmd_len;
               relu_d   = cmd_relu;
               mux_d    = cmd_mux;
               err_d    = (cmd_len == '0);
               issued_d = '0;
               ret_d    = '0;
               state_d  = (cmd_len == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (wb_v) ret_d = ret_inc;
            if (rf_rd_gnt) begin
               issued_d = issued_q + CNT_W'(1);
               if (issued_q + CNT_W'(1) == len_ext) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            ret_d = ret_inc;
            if (ret_inc == len_ext) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, command and delay-line registers; reset drops any in-flight beats.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         len_q    <= '0;
         relu_q   <= 1'b0;
         mux_q    <= '0;
         err_q    <= 1'b0;
         issued_q <= '0;
         ret_q    <= '0;
         dl_v_q   <= '0;
         for (int i = 0; i < RD_LAT; i++) dl_idx_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         len_q    <= len_d;
         relu_q   <= relu_d;
         mux_q    <= mux_d;
         err_q    <= err_d;
         issued_q <= issued_d;
         ret_q    <= ret_d;
         dl_v_q   <= dl_v_d;
         for (int i = 0; i < RD_LAT; i++) dl_idx_q[i] <= dl_idx_d[i];
      end
   end

   assign cmd_ready   = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign err_len     = (state_q == S_DONE) && err_q;
   assign rf_rd_req   = (state_q == S_ISSUE);
   assign rf_rd_idx   = (state_q == S_ISSUE) ? rd_idx : '0;
   assign relu_data_v = dl_v_q[RD_LAT-1];
   assign relu_rf_idx = dl_idx_q[RD_LAT-1];
   assign relu_en     = busy && relu_q;
   assign relu_rf_mux = busy ? mux_q : 2'b00;

endmodule
